// File: rtl/superscalar_hazard_scoreboard_if.sv
// Decode/execute hazard bundle between the superscalar pipeline registers and the hazard scoreboard.
// Pipeline side drives EX/decode status, the scoreboard returns stall, flush and redirect controls.
interface superscalar_hazard_scoreboard_if #(
  parameter int ISSUE_W = 2,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 32,
  parameter int SLOT_W  = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1
);
  logic [ISSUE_W-1:0]        branch_e;
  logic [ISSUE_W-1:0]        taken_e;
  logic [ISSUE_W-1:0]        predict_e;
  logic [ISSUE_W-1:0]        pc_src_d;
  logic [ISSUE_W-1:0]        mem_read_e;
  logic [ISSUE_W*REG_AW-1:0] wr_reg_e;
  logic [ISSUE_W*REG_AW-1:0] rs_d;
  logic [ISSUE_W*REG_AW-1:0] rt_d;
  logic [ISSUE_W-1:0]        stall_d;
  logic                      stall_f;
  logic                      flush_ifid;
  logic [ISSUE_W-1:0]        flush_ex;
  logic [ISSUE_W-1:0]        flush_mem;
  logic                      cpc_valid;
  logic [SLOT_W-1:0]         cpc_slot;
  logic                      recovering;
  logic [CNT_W-1:0]          stall_cnt;
  logic [CNT_W-1:0]          flush_cnt;

  modport master (
    output branch_e, taken_e, predict_e, pc_src_d, mem_read_e, wr_reg_e, rs_d, rt_d,
    input  stall_d, stall_f, flush_ifid, flush_ex, flush_mem, cpc_valid, cpc_slot,
           recovering, stall_cnt, flush_cnt
  );

  modport slave (
    input  branch_e, taken_e, predict_e, pc_src_d, mem_read_e, wr_reg_e, rs_d, rt_d,
    output stall_d, stall_f, flush_ifid, flush_ex, flush_mem, cpc_valid, cpc_slot,
           recovering, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/superscalar_hazard_scoreboard.sv
// N-way load-use / mispredict hazard unit: stall, flush and redirect outputs are combinational from
// inputs plus registered pend/FSM state; no backpressure, it only observes and steers the pipeline.
module superscalar_hazard_scoreboard #(
  parameter int ISSUE_W     = 2,
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int RECOVER_CYC = 1,
  parameter int CNT_W       = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  superscalar_hazard_scoreboard_if.slave hz_io
);
  localparam int NREG = 1 << REG_AW;
  localparam int SLOT_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;
  localparam logic [2:0] PEND_SET = 3'(LOAD_LAT - 1);
  localparam logic [1:0] RC_LOAD  = 2'(RECOVER_CYC - 1);

  typedef enum logic {RUN, RECOVER} state_e;

  state_e             state_q, state_d;
  logic [1:0]         rc_q, rc_d;
  logic [2:0]         pend_q [NREG];
  logic [2:0]         pend_d [NREG];
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic [ISSUE_W-1:0] mis, flush_mem, ld_v, src_haz, stall_d;
  logic [SLOT_W-1:0]  cpc_slot;
  logic               cpc_valid, recovering, stall_f;

  assign recovering = (state_q == RECOVER);
  assign mis        = hz_io.branch_e & (hz_io.predict_e ^ hz_io.taken_e);
  assign cpc_valid  = |mis;

  // Oldest mispredicting slot wins; everything younger in EX is killed.
  always_comb begin
    logic found;
    found     = 1'b0;
    cpc_slot  = '0;
    flush_mem = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      flush_mem[i] = found;
      if (mis[i] && !found) cpc_slot = SLOT_W'(i);
      found = found | mis[i];
    end
  end

  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) begin
      ld_v[i] = hz_io.mem_read_e[i] && (hz_io.wr_reg_e[i*REG_AW +: REG_AW] != '0) && !flush_mem[i];
    end
  end

  always_comb begin
    logic [REG_AW-1:0] src;
    logic              hit;
    src_haz = '0;
    src     = '0;
    hit     = 1'b0;
    for (int j = 0; j < ISSUE_W; j++) begin
      for (int s = 0; s < 2; s++) begin
        src = (s == 0) ? hz_io.rs_d[j*REG_AW +: REG_AW] : hz_io.rt_d[j*REG_AW +: REG_AW];
        hit = (pend_q[src] != 3'd0);
        for (int i = 0; i < ISSUE_W; i++) begin
          hit = hit | (ld_v[i] && (hz_io.wr_reg_e[i*REG_AW +: REG_AW] == src));
        end
        if (src != '0 && hit) src_haz[j] = 1'b1;
      end
    end
  end

  // In-order issue: the first hazardous slot holds itself and every younger slot.
  always_comb begin
    logic acc;
    acc = 1'b0;
    for (int j = 0; j < ISSUE_W; j++) begin
      acc        = acc | src_haz[j];
      stall_d[j] = acc & ~(cpc_valid | recovering);
    end
  end

  assign stall_f = |stall_d;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend_d[r] = (pend_q[r] != 3'd0) ? pend_q[r] - 3'd1 : 3'd0;
    end
    for (int i = 0; i < ISSUE_W; i++) begin
      if (ld_v[i]) pend_d[hz_io.wr_reg_e[i*REG_AW +: REG_AW]] = PEND_SET;
    end
    pend_d[0] = 3'd0;
  end

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    if (cpc_valid) begin
      state_d = RECOVER;
      rc_d    = RC_LOAD;
    end else if (state_q == RECOVER) begin
      if (rc_q == 2'd0) state_d = RUN;
      else              rc_d    = rc_q - 2'd1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_f && (stall_cnt_q != '1))   stall_cnt_d = stall_cnt_q + 1'b1;
    if (cpc_valid && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '{default: 3'd0};
      state_q     <= RUN;
      rc_q        <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pend_q      <= pend_d;
      state_q     <= state_d;
      rc_q        <= rc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz_io.stall_d    = stall_d;
  assign hz_io.stall_f    = stall_f;
  assign hz_io.flush_ifid = cpc_valid | (|hz_io.pc_src_d) | recovering;
  assign hz_io.flush_ex   = cpc_valid ? '1 : stall_d;
  assign hz_io.flush_mem  = flush_mem;
  assign hz_io.cpc_valid  = cpc_valid;
  assign hz_io.cpc_slot   = cpc_slot;
  assign hz_io.recovering = recovering;
  assign hz_io.stall_cnt  = stall_cnt_q;
  assign hz_io.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_superscalar_hazard_scoreboard.sv
// Randomised plus directed check of the hazard scoreboard against a cycle-stamp reference model.
module tb_superscalar_hazard_scoreboard;
  localparam int W = 2, AW = 5, LL = 3, RC = 2, CW = 4, SW = 1;
  localparam int NREG = 1 << AW;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [W-1:0]  stall_d, flush_ex, flush_mem;
    logic          stall_f, flush_ifid, cpc_valid, recovering;
    logic [SW-1:0] cpc_slot;
    logic [CW-1:0] stall_cnt, flush_cnt;
  } exp_t;

  logic clk, rst;
  superscalar_hazard_scoreboard_if #(.ISSUE_W(W), .REG_AW(AW), .CNT_W(CW)) hz();

  superscalar_hazard_scoreboard #(
    .ISSUE_W(W), .REG_AW(AW), .LOAD_LAT(LL), .RECOVER_CYC(RC), .CNT_W(CW)
  ) dut (.clk(clk), .rst(rst), .hz_io(hz));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   busy_until[NREG];  // last cycle a register is still waiting on an in-flight load
  int   rec_until;         // last cycle decode is masked after a mispredict
  int   n_stall, n_flush, cyc, mon_cyc;
  int   n_checks = 0, n_fail = 0;

  function automatic logic [W*AW-1:0] pk(input int a0, input int a1);
    return {AW'(a1), AW'(a0)};
  endfunction

  task automatic step(input logic r, input logic [W-1:0] br, tk, pr, pcs, mr,
                      input logic [W*AW-1:0] wr, rs, rt, input bit chk);
    exp_t e;
    int   k, ra, wa;
    bit   any;
    rst = r;
    hz.branch_e = br; hz.taken_e = tk; hz.predict_e = pr; hz.pc_src_d = pcs;
    hz.mem_read_e = mr; hz.wr_reg_e = wr; hz.rs_d = rs; hz.rt_d = rt;
    e.recovering = (cyc <= rec_until);
    k = -1;
    for (int i = 0; i < W; i++) if (k < 0 && br[i] && (pr[i] != tk[i])) k = i;
    e.cpc_valid = (k >= 0);
    e.cpc_slot  = (k >= 0) ? SW'(k) : '0;
    for (int j = 0; j < W; j++) e.flush_mem[j] = (k >= 0) && (j > k);
    e.flush_ifid = e.cpc_valid || (pcs != '0) || e.recovering;
    any = 1'b0;
    for (int j = 0; j < W; j++) begin
      for (int s = 0; s < 2; s++) begin
        ra = (s == 0) ? int'(rs[j*AW +: AW]) : int'(rt[j*AW +: AW]);
        if (ra != 0) begin
          if (cyc <= busy_until[ra]) any = 1'b1;
          for (int i = 0; i < W; i++)
            if (mr[i] && !e.flush_mem[i] && int'(wr[i*AW +: AW]) == ra) any = 1'b1;
        end
      end
      e.stall_d[j] = any && !e.cpc_valid && !e.recovering;
    end
    e.stall_f   = (e.stall_d != '0);
    e.flush_ex  = e.cpc_valid ? {W{1'b1}} : e.stall_d;
    e.stall_cnt = CW'(n_stall);
    e.flush_cnt = CW'(n_flush);
    if (chk) exp_q.push_back(e);
    if (r) begin
      for (int q = 0; q < NREG; q++) busy_until[q] = -1;
      rec_until = -1; n_stall = 0; n_flush = 0;
    end else begin
      for (int i = 0; i < W; i++) begin
        wa = int'(wr[i*AW +: AW]);
        if (mr[i] && wa != 0 && !e.flush_mem[i]) busy_until[wa] = cyc + LL - 1;
      end
      if (e.cpc_valid) rec_until = cyc + RC;
      if (e.stall_f && n_stall < CMAX) n_stall++;
      if (e.cpc_valid && n_flush < CMAX) n_flush++;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, mon_cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall_d",    32'(hz.stall_d),    32'(e.stall_d));
      chk("stall_f",    32'(hz.stall_f),    32'(e.stall_f));
      chk("flush_ifid", 32'(hz.flush_ifid), 32'(e.flush_ifid));
      chk("flush_ex",   32'(hz.flush_ex),   32'(e.flush_ex));
      chk("flush_mem",  32'(hz.flush_mem),  32'(e.flush_mem));
      chk("cpc_valid",  32'(hz.cpc_valid),  32'(e.cpc_valid));
      chk("cpc_slot",   32'(hz.cpc_slot),   32'(e.cpc_slot));
      chk("recovering", 32'(hz.recovering), 32'(e.recovering));
      chk("stall_cnt",  32'(hz.stall_cnt),  32'(e.stall_cnt));
      chk("flush_cnt",  32'(hz.flush_cnt),  32'(e.flush_cnt));
    end
    mon_cyc++;
  end

  initial begin
    logic [W-1:0] br, tk, pr, pcs, mr;
    cyc = 0; mon_cyc = 0; rec_until = -1; n_stall = 0; n_flush = 0;
    for (int q = 0; q < NREG; q++) busy_until[q] = -1;
    rst = 1'b1;
    @(posedge clk); #1;
    mon_cyc = 0;
    step(1, '0, '0, '0, '0, '0, '0, '0, '0, 0);
    step(1, '0, '0, '0, '0, '0, '0, '0, '0, 1);
    // slot1 load to r5, slot0 reads r5 -> whole group stalls
    step(0, '0, '0, '0, '0, 2'b10, pk(0, 5), pk(5, 0), '0, 1);
    repeat (3) step(0, '0, '0, '0, '0, '0, '0, '0, '0, 1);
    // slot0 independent, slot1 dependent -> only slot1 held
    step(0, '0, '0, '0, '0, 2'b10, pk(0, 5), pk(3, 5), '0, 1);
    repeat (3) step(0, '0, '0, '0, '0, '0, '0, '0, '0, 1);
    step(0, '0, '0, '0, '0, 2'b11, pk(0, 0), pk(3, 4), pk(0, 6), 1);
    // multi-cycle load latency on r7
    step(0, '0, '0, '0, '0, 2'b01, pk(7, 0), '0, '0, 1);
    repeat (3) step(0, '0, '0, '0, '0, '0, '0, '0, pk(0, 7), 1);
    // slot0 mispredict kills the slot1 load to r4
    step(0, 2'b11, 2'b01, 2'b00, '0, 2'b10, pk(0, 4), pk(4, 0), '0, 1);
    repeat (4) step(0, '0, '0, '0, '0, '0, '0, pk(4, 4), '0, 1);
    // back-to-back mispredicts extend recovery; a slot1 mispredict selects slot 1
    step(0, 2'b01, 2'b01, 2'b00, '0, '0, '0, '0, '0, 1);
    step(0, 2'b10, 2'b00, 2'b10, 2'b01, '0, '0, '0, '0, 1);
    repeat (4) step(0, '0, '0, '0, '0, '0, '0, '0, '0, 1);
    // reset during recovery with r7 pending
    step(0, 2'b01, 2'b01, 2'b00, '0, 2'b01, pk(7, 0), '0, '0, 1);
    step(1, '0, '0, '0, '0, '0, '0, '0, '0, 1);
    repeat (2) step(0, '0, '0, '0, '0, '0, '0, pk(7, 0), pk(0, 7), 1);
    // stall counter saturation
    repeat (20) step(0, '0, '0, '0, '0, 2'b01, pk(5, 0), pk(5, 0), '0, 1);
    repeat (2) step(0, '0, '0, '0, '0, '0, '0, '0, '0, 1);
    for (int n = 0; n < 2000; n++) begin
      for (int b = 0; b < W; b++) begin
        br[b]  = ($urandom_range(0, 2) == 0);
        tk[b]  = 1'($urandom);
        pr[b]  = tk[b] ^ ($urandom_range(0, 3) == 0);
        pcs[b] = ($urandom_range(0, 15) == 0);
        mr[b]  = ($urandom_range(0, 1) == 0);
      end
      step(($urandom_range(0, 63) == 0), br, tk, pr, pcs, mr,
           pk($urandom_range(0, 7), $urandom_range(0, 7)),
           pk($urandom_range(0, 7), $urandom_range(0, 7)),
           pk($urandom_range(0, 7), $urandom_range(0, 7)), 1);
    end
    step(0, '0, '0, '0, '0, '0, '0, '0, '0, 1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
